// File: rtl/adam_mem_pause_seq.sv
// Pauses NO_MEMS memories one at a time in ascending order, resumes them in descending order,
// and can pulse soft-resets while paused. Optional ack timeout: define ADAM_PAUSE_TIMEOUT_EN.
module adam_mem_pause_seq #(
    parameter int NO_MEMS     = 5,
    parameter int SRST_CYCLES = 4,
    parameter int TIMEOUT     = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pause_req,
    output logic               pause_ack,
    output logic [NO_MEMS-1:0] mem_pause_req,
    input  logic [NO_MEMS-1:0] mem_pause_ack,
    input  logic [NO_MEMS-1:0] srst_req,
    output logic [NO_MEMS-1:0] mem_srst,
    output logic               srst_done,
    output logic [NO_MEMS-1:0] timeout_err
);

    localparam int IDX_W = (NO_MEMS > 1) ? $clog2(NO_MEMS) : 1;
    localparam int SC_W  = $clog2(SRST_CYCLES + 1);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NO_MEMS - 1);
    localparam logic [SC_W-1:0]    SC_LAST  = SC_W'(SRST_CYCLES - 1);
    localparam logic [NO_MEMS-1:0] ONE      = NO_MEMS'(1);

    typedef enum logic [2:0] {
        RUN,
        PAUSING,
        PAUSED,
        SRST,
        RESUMING
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NO_MEMS-1:0] req_q, req_d;
    logic               pause_ack_q, pause_ack_d;
    logic [NO_MEMS-1:0] srst_q, srst_d;
    logic               srst_done_q, srst_done_d;
    logic [SC_W-1:0]    scnt_q, scnt_d;
    logic [NO_MEMS-1:0] ack_shift;
    logic               ack_cur;
    logic               step_expired;

    // Shift rather than bit-select so the index width never exceeds the vector range.
    assign ack_shift = mem_pause_ack >> idx_q;
    assign ack_cur   = ack_shift[0];

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        req_d       = req_q;
        pause_ack_d = pause_ack_q;
        srst_d      = srst_q;
        srst_done_d = 1'b0;
        scnt_d      = scnt_q;
        case (state_q)
            RUN: begin
                if (pause_req) begin
                    state_d = PAUSING;
                    idx_d   = '0;
                    req_d   = req_q | ONE;
                end
            end
            PAUSING: begin
                if (ack_cur || step_expired) begin
                    if (idx_q == IDX_LAST) begin
                        state_d     = PAUSED;
                        pause_ack_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        req_d = req_q | (ONE << idx_d);
                    end
                end
            end
            PAUSED: begin
                // Resume wins over a simultaneous soft-reset request.
                if (!pause_req) begin
                    state_d = RESUMING;
                    idx_d   = IDX_LAST;
                    req_d   = req_q & ~(ONE << IDX_LAST);
                end else if (|srst_req) begin
                    state_d = SRST;
                    srst_d  = srst_req;
                    scnt_d  = '0;
                end
            end
            SRST: begin
                if (scnt_q == SC_LAST) begin
                    state_d     = PAUSED;
                    srst_d      = '0;
                    srst_done_d = 1'b1;
                    scnt_d      = '0;
                end else begin
                    scnt_d = scnt_q + SC_W'(1);
                end
            end
            RESUMING: begin
                if (!ack_cur || step_expired) begin
                    if (idx_q == '0) begin
                        state_d     = RUN;
                        pause_ack_d = 1'b0;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                        req_d = req_q & ~(ONE << idx_d);
                    end
                end
            end
            default: state_d = PAUSED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PAUSED;
            idx_q       <= IDX_LAST;
            req_q       <= '1;
            pause_ack_q <= 1'b1;
            srst_q      <= '0;
            srst_done_q <= 1'b0;
            scnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            req_q       <= req_d;
            pause_ack_q <= pause_ack_d;
            srst_q      <= srst_d;
            srst_done_q <= srst_done_d;
            scnt_q      <= scnt_d;
        end
    end

`ifdef ADAM_PAUSE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0]    wait_q, wait_d;
    logic [NO_MEMS-1:0] terr_q, terr_d;
    logic               to_hit;

    assign step_expired = (wait_q == TO_LAST);
    assign to_hit = step_expired &&
                    (((state_q == PAUSING) && !ack_cur) || ((state_q == RESUMING) && ack_cur));

    // The wait restarts whenever the step (state or index) moves on.
    always_comb begin
        wait_d = wait_q + TO_W'(1);
        if ((state_d != state_q) || (idx_d != idx_q) ||
            !((state_q == PAUSING) || (state_q == RESUMING))) begin
            wait_d = '0;
        end
        terr_d = terr_q;
        if (to_hit) begin
            terr_d = terr_q | (ONE << idx_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q <= '0;
            terr_q <= '0;
        end else begin
            wait_q <= wait_d;
            terr_q <= terr_d;
        end
    end

    assign timeout_err = terr_q;
`else
    assign step_expired = 1'b0;
    assign timeout_err  = '0;
`endif

    assign pause_ack     = pause_ack_q;
    assign mem_pause_req = req_q;
    assign mem_srst      = srst_q;
    assign srst_done     = srst_done_q;

endmodule
